game_autoplayer: RTL

- Scripted opponent that drives the human-side button/switch inputs of the Mastermind-style game FSM: hMove nibble, enter_L and new_game_L.
- Issues a new-game pulse, then presents up to MAX_MOVES moves, each with a timed enter press.
- Captures the FSM's cMove reply and win flag after every press.
- Used for board self-play demos and as a bench driver for the game FSM.

---
 rtl/game_pkg.sv | 17 +
 rtl/button_pulser.sv | 15 +
 rtl/game_autoplayer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game autoplayer.
// The LFSR helper is used only when AUTOPLAY_LFSR_EN is defined.
package game_pkg;

  typedef enum logic [2:0] {IDLE, NEWGAME, SETUP, PRESS, GAP, DONE} ap_state_t;

  typedef logic [3:0] move_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/button_pulser.sv
// Active-low button decode: held low while go is high; finished flags the last cycle.
// len is the shared state counter's remaining count, so no extra timer is needed here.
module button_pulser #(
  parameter int CW = 8
) (
  input  logic          go,
  input  logic [CW-1:0] len,
  output logic          pulse_L,
  output logic          finished
);

  assign pulse_L  = ~go;
  assign finished = go && (len == '0);

endmodule

// File: rtl/game_autoplayer.sv
// Scripted opponent driving hMove/enter_L/new_game_L of the game FSM; one down-counter times every state.
// Define AUTOPLAY_LFSR_EN to take moves from a 16-bit LFSR instead of the script input.
module game_autoplayer
  import game_pkg::*;
#(
  parameter int PULSE_LEN  = 4,
  parameter int SETTLE_LEN = 2,
  parameter int GAP_LEN    = 4,
  parameter int MAX_MOVES  = 4
) (
  input  logic                   clock,
  input  logic                   reset_L,
  input  logic                   start,
  input  logic                   abort,
  input  logic [4*MAX_MOVES-1:0] script,
  input  logic [3:0]             cMove,
  input  logic                   win,
  output logic [3:0]             hMove,
  output logic                   enter_L,
  output logic                   new_game_L,
  output logic                   busy,
  output logic                   done,
  output logic                   won,
  output logic [2:0]             move_count,
  output logic [4*MAX_MOVES-1:0] cMove_log
);

  localparam int CW = 8;

  ap_state_t     state, state_nxt;
  logic [CW-1:0] cnt, load_val;
  logic          cnt_zero, ng_fin, en_fin;
  logic          accept, last_gap, enter_setup;
  logic [2:0]    mc_inc;
  move_t         next_move;

  assign cnt_zero    = (cnt == '0);
  assign mc_inc      = move_count + 3'd1;
  assign enter_setup = (state_nxt == SETUP) && (state != SETUP);
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);

  button_pulser #(.CW(CW)) u_new_game (
    .go(state == NEWGAME), .len(cnt), .pulse_L(new_game_L), .finished(ng_fin)
  );

  button_pulser #(.CW(CW)) u_enter (
    .go(state == PRESS), .len(cnt), .pulse_L(enter_L), .finished(en_fin)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_gap  = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = NEWGAME;
        accept    = 1'b1;
      end
      NEWGAME: if (ng_fin) state_nxt = SETUP;
      SETUP:   if (cnt_zero) state_nxt = PRESS;
      PRESS:   if (en_fin) state_nxt = GAP;
      GAP: if (cnt_zero) begin
        last_gap  = 1'b1;
        state_nxt = (win || mc_inc == 3'(MAX_MOVES)) ? DONE : SETUP;
      end
      default: state_nxt = IDLE;
    endcase
    // abort overrides any transition and freezes the result registers
    if (abort) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      last_gap  = 1'b0;
    end
  end

  always_comb begin
    case (state_nxt)
      NEWGAME, PRESS: load_val = CW'(PULSE_LEN - 1);
      SETUP:          load_val = CW'(SETTLE_LEN - 1);
      GAP:            load_val = CW'(GAP_LEN - 1);
      default:        load_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      cnt        <= '0;
      hMove      <= '0;
      won        <= 1'b0;
      move_count <= '0;
      cMove_log  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= load_val;
      else if (!cnt_zero)     cnt <= cnt - 1'b1;
      if (accept) begin
        won        <= 1'b0;
        move_count <= '0;
        cMove_log  <= '0;
      end
      if (last_gap) begin
        cMove_log[int'(move_count)*4 +: 4] <= cMove;
        won        <= win;
        move_count <= mc_inc;
      end
      if (enter_setup) hMove <= next_move;
    end
  end

`ifdef AUTOPLAY_LFSR_EN
  logic [15:0] lfsr, lfsr_nxt;
  logic        script_unused;

  assign script_unused = ^script;
  assign lfsr_nxt      = lfsr_step(lfsr);
  assign next_move     = lfsr_nxt[3:0];

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)         lfsr <= LFSR_SEED;
    else if (enter_setup) lfsr <= lfsr_nxt;
  end
`else
  logic [4*MAX_MOVES-1:0] script_q;
  logic [2:0]             sel;

  // coming out of GAP, move_count updates on the same edge hMove loads
  assign sel       = (state == GAP) ? mc_inc : move_count;
  assign next_move = script_q[int'(sel)*4 +: 4];

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)    script_q <= '0;
    else if (accept) script_q <= script;
  end
`endif

endmodule
